// File: rtl/sdram_arbiter.sv
// Single-port SDRAM scheduler: refresh debt, video row prefetch and CPU access share one engine.
// Optional CPU starvation guard enabled by defining ARB_CPU_GUARD_EN.
module sdram_arbiter #(
  parameter int          REFRESH_PERIOD   = 780,
  parameter int          REFRESH_MAX_DEBT = 8,
  parameter logic [25:0] VIDEO_BASE       = 26'd0,
  parameter int          VIDEO_ROW_WIDTH  = 160
`ifdef ARB_CPU_GUARD_EN
  ,
  parameter int          CPU_MAX_WAIT     = 64
`endif
) (
  input  logic        i_clock_100_mhz,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic        i_line_req,
  input  logic [9:0]  i_line_y,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [25:0] i_cpu_addr,
  output logic        o_cpu_ack,
  output logic        o_cmd_valid,
  output logic [1:0]  o_cmd_kind,
  output logic [25:0] o_cmd_addr,
  output logic [9:0]  o_cmd_len,
  input  logic        i_cmd_ready,
  input  logic        i_cmd_done,
  output logic        o_line_busy,
  output logic        o_overrun,
  output logic [3:0]  o_refresh_debt
);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, BUSY} state_t;

  localparam int          TW       = $clog2(REFRESH_PERIOD);
  localparam logic [3:0]  DEBT_MAX = 4'(REFRESH_MAX_DEBT);
  localparam logic [25:0] ROW_W26  = 26'(VIDEO_ROW_WIDTH);
  localparam logic [9:0]  ROW_LEN  = 10'(VIDEO_ROW_WIDTH);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [3:0]      debt;
  logic            line_pending;
  logic [9:0]      line_y;
  logic            grant_ref, grant_vid, grant_cpu;
  logic            cpu_eligible, cpu_starved, debt_urgent;
  logic            tick, accept, ref_acc, vid_acc;
  logic [25:0]     video_addr;

  assign tick         = (state != WAIT_INIT) && (timer == TW'(REFRESH_PERIOD - 1));
  assign accept       = (state == ISSUE) && i_cmd_ready;
  assign ref_acc      = accept && (o_cmd_kind == 2'd0);
  assign vid_acc      = accept && (o_cmd_kind == 2'd1);
  // The ack cycle still sees i_cpu_req high; masking it prevents a second grant.
  assign cpu_eligible = i_cpu_req && !o_cpu_ack;
  assign debt_urgent  = (debt == DEBT_MAX);
  assign video_addr   = VIDEO_BASE + ({16'd0, line_y} * ROW_W26);

  assign o_cmd_valid    = (state == ISSUE);
  assign o_refresh_debt = debt;
  assign o_line_busy    = line_pending || ((state == BUSY) && (o_cmd_kind == 2'd1));

`ifdef ARB_CPU_GUARD_EN
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  assign cpu_starved = cpu_eligible && (wait_cnt >= WW'(CPU_MAX_WAIT));

  always_ff @(posedge i_clock_100_mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt <= '0;
    end else if (grant_cpu) begin
      wait_cnt <= '0;
    end else if (i_cpu_req && (wait_cnt != WW'(CPU_MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign cpu_starved = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_ref = 1'b0;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      WAIT_INIT: if (i_init_done) state_nxt = IDLE;
      IDLE: begin
        if (debt_urgent)         grant_ref = 1'b1;
        else if (cpu_starved)    grant_cpu = 1'b1;
        else if (line_pending)   grant_vid = 1'b1;
        else if (cpu_eligible)   grant_cpu = 1'b1;
        else if (debt != 4'd0)   grant_ref = 1'b1;
        if (grant_ref || grant_vid || grant_cpu) state_nxt = ISSUE;
      end
      ISSUE: if (i_cmd_ready) state_nxt = BUSY;
      BUSY:  if (i_cmd_done)  state_nxt = IDLE;
      default: state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge i_clock_100_mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Descriptor is captured at the grant and held unchanged through ISSUE and BUSY.
  always_ff @(posedge i_clock_100_mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cmd_kind <= 2'd0;
      o_cmd_addr <= 26'd0;
      o_cmd_len  <= 10'd0;
    end else if (grant_ref) begin
      o_cmd_kind <= 2'd0;
      o_cmd_addr <= 26'd0;
      o_cmd_len  <= 10'd0;
    end else if (grant_vid) begin
      o_cmd_kind <= 2'd1;
      o_cmd_addr <= video_addr;
      o_cmd_len  <= ROW_LEN;
    end else if (grant_cpu) begin
      o_cmd_kind <= {1'b1, i_cpu_we};
      o_cmd_addr <= i_cpu_addr;
      o_cmd_len  <= 10'd1;
    end
  end

  always_ff @(posedge i_clock_100_mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer <= '0;
      debt  <= 4'd0;
    end else begin
      if (state == WAIT_INIT || tick) timer <= '0;
      else                            timer <= timer + 1'b1;
      if (tick && !ref_acc && !debt_urgent) debt <= debt + 4'd1;
      else if (ref_acc && !tick)            debt <= debt - 4'd1;
    end
  end

  always_ff @(posedge i_clock_100_mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      line_pending <= 1'b0;
      line_y       <= 10'd0;
      o_overrun    <= 1'b0;
      o_cpu_ack    <= 1'b0;
    end else begin
      if (vid_acc) line_pending <= 1'b0;
      // A request landing on the acceptance edge refills the slot instead of overrunning.
      if (i_line_req && (!line_pending || vid_acc)) begin
        line_pending <= 1'b1;
        line_y       <= i_line_y;
      end
      o_overrun <= i_line_req && line_pending && !vid_acc;
      o_cpu_ack <= (state == BUSY) && i_cmd_done && o_cmd_kind[1];
    end
  end

endmodule
